cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and reset_n.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 s  input  1  start; sampled only in WAIT.
REQ-005 in  input  16  instruction word; captured into IR when s is accepted.
REQ-006 Z_in  input  3  ALU status: bit0 zero, bit1 overflow, bit2 negative.
REQ-007 w  output  1  idle/ready; high only in WAIT.
REQ-008 ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B.
REQ-009 shift  output  2  IR[4:3] in every state.
REQ-010 readnum, writenum  output  3 each  register-file read and write addresses.
REQ-011 write, loada, loadb, loadc, loads  output  1 each  single-cycle strobes.
REQ-012 asel, bsel  output  1 each  operand select; asel=1 forces A operand to zero.
REQ-013 vsel  output  2  writeback select: 00 datapath C, 01 sximm8.
REQ-014 sximm8  output  16  IR[7:0] sign-extended.
REQ-015 status  output  3  registered ALU flags.

Function
REQ-016 IR fields SHALL be opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
REQ-017 FSM states SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-018 WAIT with s=1 SHALL load IR from in and go to DECODE; changes on in after acceptance SHALL have no effect.
REQ-019 DECODE SHALL go to WRITE_IMM for 110/10, GET_B for 110/00 and 101/11, GET_A for 101/00, 101/01 and 101/10, and WAIT for all other opcodes, with no strobes.
REQ-020 WRITE_IMM: write=1, writenum=Rn, vsel=01; next state WAIT.
REQ-021 GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-022 GET_B: readnum=Rm, loadb=1; next state ALU.
REQ-023 ALU: bsel=0; ALUop=op, except MOV-reg (110/00), which uses ALUop=00 with asel=1.
REQ-024 In ALU, non-CMP operations SHALL assert loadc=1 and go to WRITE_REG; CMP (101/01) SHALL assert loads=1, loadc=0 and go to WAIT.
REQ-025 WRITE_REG: write=1, writenum=Rd, vsel=00; next state WAIT.
REQ-026 In any state not listed, strobes SHALL be 0, readnum, writenum, ALUop and vsel SHALL be 0, and asel and bsel SHALL be 0.
REQ-027 Latency from acceptance to w=1 SHALL be 3 cycles for MOV-imm, 4 for MOV-reg, MVN and CMP, 5 for ADD and AND, and 2 for an illegal instruction.
REQ-028 With s held high, a new instruction SHALL be accepted on every WAIT cycle, back-to-back.

Reset
REQ-029 reset_n low SHALL force state WAIT, IR=0 and status=0 immediately, independent of clk.
REQ-030 While reset_n is low, w SHALL be 1, all strobes 0, and s ignored.
REQ-031 Reset mid-instruction SHALL abort it, and no later write or loads strobe SHALL result.

Configuration
REQ-032 With CPU_STATUS_REG_EN defined, status SHALL load Z_in on the clock edge ending the ALU state of a CMP.
REQ-033 Without CPU_STATUS_REG_EN, status SHALL be tied to 000, loads SHALL stay 0, and CMP SHALL still traverse GET_A, GET_B and ALU with no architectural effect.

Structure
REQ-034 Package cpu_pkg SHALL hold the state enum, opcode/op constants, ALUop encodings and vsel encodings.
REQ-035 Sub-module instr_dec (combinational) SHALL extract IR fields and produce sximm8; all sequential logic SHALL stay in cpu_ctrl.

Verification
REQ-036 MOV R3,#-5: in=16'hD3FB with an s pulse -> WRITE_IMM cycle shows write=1, writenum=3, vsel=01, sximm8=16'hFFFB; w=1 3 cycles after acceptance.
REQ-037 ADD R2,R1,R0: in=16'hA140 -> loada with readnum=1, then loadb with readnum=0, then loadc with ALUop=00, then write with writenum=2; w=1 after 5 cycles.
REQ-038 CMP R1,R1: in=16'hA901, Z_in=001 in the ALU cycle -> status=001, no write; without the macro, status remains 000 and loads stays 0.
REQ-039 MVN R4,R5,LSL: in=16'hB88D -> GET_A skipped, shift=01, ALUop=11, write with writenum=4 after 4 cycles.
REQ-040 reset_n low during GET_B of 16'hA140 -> immediate WAIT and w=1, no write; in=16'hE000 -> WAIT after 2 cycles with no strobes.
REQ-041 s held high with 16'hD3FB then 16'hA140 -> second instruction accepted in the first WAIT cycle after the first completes.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state codes, opcode/op constants, ALUop/vsel encodings and decode helpers
package cpu_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_WAIT      = 3'd0;
  localparam state_t S_DECODE    = 3'd1;
  localparam state_t S_WRITE_IMM = 3'd2;
  localparam state_t S_GET_A     = 3'd3;
  localparam state_t S_GET_B     = 3'd4;
  localparam state_t S_ALU       = 3'd5;
  localparam state_t S_WRITE_REG = 3'd6;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sximm8;
  } fields_t;
  // MOV-reg and MVN need no A operand, so they skip straight to GET_B
  function automatic state_t decode_next(input logic [2:0] opcode, input logic [1:0] op);
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: decode_next = S_WRITE_IMM;
      {OPC_MOV, OP_MOV_REG},
      {OPC_ALU, OP_MVN}:     decode_next = S_GET_B;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_CMP},
      {OPC_ALU, OP_AND}:     decode_next = S_GET_A;
      default:               decode_next = S_WAIT;
    endcase
  endfunction
endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction/status inputs and datapath control outputs of the CPU controller
interface cpu_ctrl_if;
  logic        s;
  logic [15:0] in;
  logic [2:0]  Z_in;
  logic        w;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [15:0] sximm8;
  logic [2:0]  status;
  modport master (
    input  s, in, Z_in,
    output w, ALUop, shift, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, sximm8, status
  );
  modport slave (
    output s, in, Z_in,
    input  w, ALUop, shift, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, sximm8, status
  );
endinterface

// File: rtl/cpu_ctrl_instr_dec.sv
// instr_dec: splits the instruction register into its fields and sign-extends imm8
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output fields_t     f
);
  assign f.opcode = ir[15:13];
  assign f.op     = ir[12:11];
  assign f.rn     = ir[10:8];
  assign f.rd     = ir[7:5];
  assign f.sh     = ir[4:3];
  assign f.rm     = ir[2:0];
  assign f.sximm8 = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer driving register file, ALU and status strobes.
// Define CPU_STATUS_REG_EN to make CMP latch the ALU flags into status.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cpu_ctrl_if.master bus
);
  state_t  state;
  state_t  next;
  logic [15:0] ir;
  fields_t f;
  logic    alu;
  logic    mov_reg;
  logic    is_cmp;
  instr_dec u_dec (.ir(ir), .f(f));
  assign alu     = state == S_ALU;
  assign mov_reg = f.opcode == OPC_MOV && f.op == OP_MOV_REG;
  assign is_cmp  = f.opcode == OPC_ALU && f.op == OP_CMP;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && bus.s) ir <= bus.in;
    end
  always_comb begin
    next = S_WAIT;
    case (state)
      S_WAIT:   next = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: next = decode_next(f.opcode, f.op);
      S_GET_A:  next = S_GET_B;
      S_GET_B:  next = S_ALU;
      S_ALU:    next = is_cmp ? S_WAIT : S_WRITE_REG;
      default:  next = S_WAIT;
    endcase
  end
  assign bus.w        = state == S_WAIT;
  assign bus.write    = state == S_WRITE_IMM || state == S_WRITE_REG;
  assign bus.loada    = state == S_GET_A;
  assign bus.loadb    = state == S_GET_B;
  assign bus.loadc    = alu && !is_cmp;
  assign bus.readnum  = state == S_GET_A ? f.rn : state == S_GET_B ? f.rm : 3'd0;
  assign bus.writenum = state == S_WRITE_IMM ? f.rn : state == S_WRITE_REG ? f.rd : 3'd0;
  assign bus.vsel     = state == S_WRITE_IMM ? VSEL_IMM : VSEL_C;
  // MOV-reg passes B through the adder with A forced to zero
  assign bus.ALUop    = alu && !mov_reg ? f.op : ALU_ADD;
  assign bus.asel     = alu && mov_reg;
  assign bus.bsel     = 1'b0;
  assign bus.shift    = f.sh;
  assign bus.sximm8   = f.sximm8;
`ifdef CPU_STATUS_REG_EN
  logic [2:0] status_q;
  assign bus.loads = alu && is_cmp;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) status_q <= '0;
    else if (bus.loads) status_q <= bus.Z_in;
  assign bus.status = status_q;
`else
  assign bus.loads  = 1'b0;
  assign bus.status = 3'b000;
`endif
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed per-instruction cycle-by-cycle checks of the cpu_ctrl strobes and state latency
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int pass_n = 0;
  int total_n = 0;
  cpu_ctrl_if bus ();
  cpu_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
  always #5 clk = ~clk;
`ifdef CPU_STATUS_REG_EN
  localparam logic       LS     = 1'b1;
  localparam logic [2:0] CMP_ST = 3'b001;
`else
  localparam logic       LS     = 1'b0;
  localparam logic [2:0] CMP_ST = 3'b000;
`endif
  logic [17:0] obs;
  assign obs = {bus.w, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel,
                bus.vsel, bus.ALUop, bus.readnum, bus.writenum};
  function automatic logic [17:0] cv(input logic w, wr, la, lb, lc, ls, as, bs,
                                     input logic [1:0] vs, aop, input logic [2:0] rn, wn);
    return {w, wr, la, lb, lc, ls, as, bs, vs, aop, rn, wn};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [15:0] word);
    bus.s  = 1'b1;
    bus.in = word;
    step();
    bus.s  = 1'b0;
    bus.in = 16'hFFFF;
  endtask
  task automatic test_reset();
    logic [17:0] idle;
    idle = cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0);
    bus.s = 1'b1; bus.in = 16'hA140; bus.Z_in = 3'b111;
    #3;
    total_n++;
    if (obs !== idle) $display("FAIL reset_ctrl: got %h want %h", obs, idle); else pass_n++;
    total_n++;
    if (bus.status !== 3'b000) $display("FAIL reset_status: got %b want 000", bus.status); else pass_n++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_n++;
      if (obs !== idle) $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, idle); else pass_n++;
    end
    bus.s = 1'b0; bus.Z_in = 3'b000;
    reset_n = 1'b1;
    step();
    total_n++;
    if (obs !== idle) $display("FAIL reset_release: got %h want %h", obs, idle); else pass_n++;
  endtask
  task automatic test_mov_imm();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,1,0,0,0,0,0,0,2'b01,2'b00,3'd0,3'd3),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hD3FB);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL mov_imm cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
      if (i == 1) begin
        total_n++;
        if (bus.sximm8 !== 16'hFFFB) $display("FAIL mov_imm_sximm8: got %h want fffb", bus.sximm8); else pass_n++;
      end
    end
  endtask
  task automatic test_add();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,1,0,0,0,0,0,2'b00,2'b00,3'd1,3'd0),
         cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,0,0,1,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd2),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hA140);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL add cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
    end
  endtask
  task automatic test_and();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,1,0,0,0,0,0,2'b00,2'b00,3'd6,3'd0),
         cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd7,3'd0),
         cv(0,0,0,0,1,0,0,0,2'b00,2'b10,3'd0,3'd0),
         cv(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd1),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hB627);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL and cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
    end
  endtask
  task automatic test_cmp();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,1,0,0,0,0,0,2'b00,2'b00,3'd1,3'd0),
         cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd1,3'd0),
         cv(0,0,0,0,0,LS,0,0,2'b00,2'b01,3'd0,3'd0),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    bus.Z_in = 3'b110;
    accept(16'hA901);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      bus.Z_in = (i == 3) ? 3'b001 : (i == 4) ? 3'b111 : 3'b110;
      total_n++;
      if (obs !== e[i]) $display("FAIL cmp cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
    end
    total_n++;
    if (bus.status !== CMP_ST) $display("FAIL cmp_status: got %b want %b", bus.status, CMP_ST); else pass_n++;
    step();
    bus.Z_in = 3'b000;
    total_n++;
    if (bus.status !== CMP_ST) $display("FAIL cmp_status_hold: got %b want %b", bus.status, CMP_ST); else pass_n++;
  endtask
  task automatic test_mvn();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd5,3'd0),
         cv(0,0,0,0,1,0,0,0,2'b00,2'b11,3'd0,3'd0),
         cv(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd4),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hB88D);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL mvn cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
      if (i == 2) begin
        total_n++;
        if (bus.shift !== 2'b01) $display("FAIL mvn_shift: got %b want 01", bus.shift); else pass_n++;
      end
    end
  endtask
  task automatic test_mov_reg();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'd2,3'd0),
         cv(0,0,0,0,1,0,1,0,2'b00,2'b00,3'd0,3'd0),
         cv(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd3),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hC072);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL mov_reg cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
    end
  endtask
  task automatic test_illegal();
    logic [17:0] e[$];
    e = {cv(0,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0),
         cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0)};
    accept(16'hE000);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      total_n++;
      if (obs !== e[i]) $display("FAIL illegal cyc%0d: got %h want %h", i, obs, e[i]); else pass_n++;
    end
  endtask
  task automatic test_reset_mid();
    logic [17:0] idle;
    idle = cv(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0);
    accept(16'hA140);
    step();
    step();
    total_n++;
    if (bus.loadb !== 1'b1) $display("FAIL abort_in_get_b: got loadb=%b want 1", bus.loadb); else pass_n++;
    #1 reset_n = 1'b0;
    #1;
    total_n++;
    if (obs !== idle) $display("FAIL abort_immediate: got %h want %h", obs, idle); else pass_n++;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total_n++;
      if (obs !== idle) $display("FAIL abort_after cyc%0d: got %h want %h", i, obs, idle); else pass_n++;
    end
  endtask
  task automatic test_back_to_back();
    bus.s = 1'b1; bus.in = 16'hD3FB;
    step();
    bus.in = 16'hA140;
    total_n++;
    if (bus.w !== 1'b0) $display("FAIL b2b_decode1: got w=%b want 0", bus.w); else pass_n++;
    step();
    total_n++;
    if ({bus.write, bus.writenum} !== {1'b1, 3'd3})
      $display("FAIL b2b_write_imm: got write=%b writenum=%0d want 1/3", bus.write, bus.writenum);
    else pass_n++;
    step();
    total_n++;
    if (bus.w !== 1'b1) $display("FAIL b2b_wait: got w=%b want 1", bus.w); else pass_n++;
    step();
    total_n++;
    if (bus.w !== 1'b0) $display("FAIL b2b_accept2: got w=%b want 0", bus.w); else pass_n++;
    bus.s = 1'b0;
    step();
    total_n++;
    if ({bus.loada, bus.readnum} !== {1'b1, 3'd1})
      $display("FAIL b2b_get_a: got loada=%b readnum=%0d want 1/1", bus.loada, bus.readnum);
    else pass_n++;
    for (int i = 0; i < 4; i++) step();
    total_n++;
    if (bus.w !== 1'b1) $display("FAIL b2b_done: got w=%b want 1", bus.w); else pass_n++;
  endtask
  initial begin
    bus.s = 1'b0; bus.in = 16'h0000; bus.Z_in = 3'b000;
    test_reset();
    test_mov_imm();
    test_add();
    test_and();
    test_cmp();
    test_mvn();
    test_mov_reg();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
